// File: rtl/gps_uart_pkg.sv
// ============================================================================
// Module      : gps_uart_pkg
// Description : Shared types and helpers for the GPS config UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gps_uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_t;

    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

    // Smallest width able to hold 0 .. clks_per_bit-1.
    function automatic int cnt_width(input int clks_per_bit);
        int w;
        w = 1;
        while ((1 << w) < clks_per_bit)
            w = w + 1;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gps_bit_sync.sv
// ============================================================================
// Module      : gps_bit_sync
// Description : Two-flop synchroniser for asynchronous single-bit inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gps_bit_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/gps_uart_rx.sv
// ============================================================================
// Module      : gps_uart_rx
// Description : 8N1 UART receiver feeding the GPS generator register bank.
//               Define GPS_UART_RX_PARITY_EN to add an even-parity bit.
//               CLKS_PER_BIT must be at least 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gps_uart_rx
    import gps_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 142
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       frame_err_out,
    output logic       parity_err_out,
    output logic       busy_out
);

    localparam int c_half  = half_bit(CLKS_PER_BIT);
    localparam int c_cnt_w = cnt_width(CLKS_PER_BIT);

    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_half - 1);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [2:0]         c_last_bit  = 3'(DATA_BITS - 1);

    logic                 w_rx_s;
    uart_state_t          r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 w_par_bad;

`ifdef GPS_UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;
    assign w_par_bad      = r_par_bad;
    assign parity_err_out = r_parity_err;
`else
    assign w_par_bad      = 1'b0;
    assign parity_err_out = 1'b0;
`endif

    gps_bit_sync #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk_in),
        .rst (rst_in),
        .i_d (rx_in),
        .o_q (w_rx_s)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef GPS_UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef GPS_UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                // Re-check the start bit at its midpoint to reject glitches.
                START: begin
                    if (r_cnt == c_half_last) begin
                        if (!w_rx_s) begin
                            r_state   <= DATA;
                            r_cnt     <= '0;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                DATA: begin
                    if (r_cnt == c_bit_last) begin
                        r_shift[r_bit_idx] <= w_rx_s;
                        r_cnt              <= '0;
                        r_bit_idx          <= r_bit_idx + 3'd1;
                        if (r_bit_idx == c_last_bit) begin
`ifdef GPS_UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
`ifdef GPS_UART_RX_PARITY_EN
                PARITY: begin
                    if (r_cnt == c_bit_last) begin
                        r_par_bad <= (^r_shift) ^ w_rx_s;
                        r_cnt     <= '0;
                        r_state   <= STOP;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
`endif
                // Leave at mid-stop so a following start edge is never missed.
                STOP: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= IDLE;
                            if (w_par_bad) begin
`ifdef GPS_UART_RX_PARITY_EN
                                r_parity_err <= 1'b1;
`endif
                            end else begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end
                        end else begin
                            r_state     <= BREAK;
                            r_frame_err <= 1'b1;
`ifdef GPS_UART_RX_PARITY_EN
                            r_parity_err <= r_par_bad;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                BREAK: begin
                    if (w_rx_s)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_out      = r_data;
    assign valid_out     = r_valid;
    assign frame_err_out = r_frame_err;
    assign busy_out      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_gps_uart_rx.sv
// ============================================================================
// Module      : tb_gps_uart_rx
// Description : Self-checking bench for gps_uart_rx against an event model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gps_uart_rx;

    localparam int CPB  = 142;
    localparam int HALF = CPB / 2;
`ifdef GPS_UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Edges from first low sample to the result pulse.
    localparam int LAT = HALF + 2 + (NBITS - 1) * CPB;

    localparam int K_VALID  = 0;
    localparam int K_FRAME  = 1;
    localparam int K_PARITY = 2;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       rx_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       frame_err_out;
    logic       parity_err_out;
    logic       busy_out;

    typedef struct {
        int         t;
        int         kind;
        logic [7:0] d;
    } evt_t;

    evt_t       got_q[$];
    evt_t       exp_q[$];
    int         cyc      = 0;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_data = 8'h00;

    gps_uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rx_in          (rx_in),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .frame_err_out  (frame_err_out),
        .parity_err_out (parity_err_out),
        .busy_out       (busy_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc = cyc + 1;

    always @(negedge clk_in) begin
        if (valid_out)      got_q.push_back('{cyc, K_VALID,  data_out});
        if (frame_err_out)  got_q.push_back('{cyc, K_FRAME,  data_out});
        if (parity_err_out) got_q.push_back('{cyc, K_PARITY, data_out});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk_in);
    endtask

    // Drives one frame starting at the current negedge; stops after
    // abort_bits bit periods when that is shorter than the frame.
    task automatic send_frame(input logic [7:0] b, input bit par_ok,
                              input bit stop_ok, input int abort_bits);
        logic [10:0] seq;
        int          t0;
        seq    = '1;
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[1 + i] = b[i];
`ifdef GPS_UART_RX_PARITY_EN
        seq[9]  = par_ok ? ^b : ~^b;
        seq[10] = stop_ok;
`else
        seq[9]  = stop_ok;
`endif
        t0 = cyc;
        if (abort_bits >= NBITS) begin
            if (!stop_ok) begin
                exp_q.push_back('{t0 + 1 + LAT, K_FRAME, exp_data});
                if (!par_ok) exp_q.push_back('{t0 + 1 + LAT, K_PARITY, exp_data});
            end else if (!par_ok) begin
                exp_q.push_back('{t0 + 1 + LAT, K_PARITY, exp_data});
            end else begin
                exp_data = b;
                exp_q.push_back('{t0 + 1 + LAT, K_VALID, b});
            end
        end
        for (int i = 0; i < NBITS && i < abort_bits; i++) begin
            rx_in = seq[i];
            repeat (CPB) @(negedge clk_in);
        end
    endtask

    task automatic compare_events(input string tag);
        evt_t g;
        evt_t e;
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check_eq({tag, "_time"}, g.t, e.t);
            check_eq({tag, "_kind"}, g.kind, e.kind);
            check_eq({tag, "_data"}, {24'd0, g.d}, {24'd0, e.d});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bit         par_ok;
        bit         stop_ok;
        logic [7:0] b;

        rx_in  = 1'b1;
        rst_in = 1'b1;
        @(negedge clk_in);
        repeat (4) @(negedge clk_in);
        check_eq("rst_data",   data_out, 32'h00);
        check_eq("rst_valid",  valid_out, 0);
        check_eq("rst_ferr",   frame_err_out, 0);
        check_eq("rst_perr",   parity_err_out, 0);
        check_eq("rst_busy",   busy_out, 0);
        rst_in = 1'b0;

        idle(5000);
        check_eq("idle_busy", busy_out, 0);
        check_eq("idle_data", data_out, 32'h00);
        compare_events("idle");

        send_frame(8'hA5, 1'b1, 1'b1, 99);
        idle(50);
        compare_events("a5");
        check_eq("a5_data", data_out, 32'hA5);

        // Short low glitch must be rejected at the start-bit midpoint.
        rx_in = 1'b0;
        repeat (30) @(negedge clk_in);
        check_eq("glitch_busy_mid", busy_out, 1);
        idle(200);
        check_eq("glitch_busy_end", busy_out, 0);
        check_eq("glitch_data", data_out, exp_data);
        compare_events("glitch");

        send_frame(8'h3C, 1'b1, 1'b0, 99);
        repeat (3 * CPB) @(negedge clk_in);
        check_eq("break_busy", busy_out, 1);
        check_eq("break_data", data_out, 32'hA5);
        compare_events("ferr");
        idle(50);
        check_eq("break_exit_busy", busy_out, 0);
        send_frame(8'h01, 1'b1, 1'b1, 99);
        idle(50);
        compare_events("after_ferr");
        check_eq("after_ferr_data", data_out, 32'h01);

        send_frame(8'h00, 1'b1, 1'b1, 99);
        send_frame(8'hFF, 1'b1, 1'b1, 99);
        send_frame(8'h55, 1'b1, 1'b1, 99);
        check_eq("b2b_data", data_out, 32'h55);
        send_frame(8'h96, 1'b1, 1'b1, 5);
        rst_in = 1'b1;
        rx_in  = 1'b1;
        repeat (3) @(negedge clk_in);
        exp_data = 8'h00;
        check_eq("midrst_data", data_out, 32'h00);
        check_eq("midrst_busy", busy_out, 0);
        rst_in = 1'b0;
        idle(12 * CPB);
        compare_events("b2b");
        check_eq("post_rst_busy", busy_out, 0);

`ifdef GPS_UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 99);
        idle(20);
        send_frame(8'h07, 1'b0, 1'b1, 99);
        idle(20);
        compare_events("par07");
        check_eq("par07_data", data_out, 32'h07);
`endif

        for (int n = 0; n < 16; n++) begin
            b       = 8'($urandom);
            stop_ok = ($urandom_range(0, 5) != 0);
`ifdef GPS_UART_RX_PARITY_EN
            par_ok  = ($urandom_range(0, 3) != 0);
`else
            par_ok  = 1'b1;
`endif
            send_frame(b, par_ok, stop_ok, 99);
            if (!stop_ok)
                idle($urandom_range(8, 2 * CPB));
            else if ($urandom_range(0, 1) == 1)
                idle($urandom_range(1, 300));
        end
        idle(50);
        compare_events("rand");
        check_eq("rand_data", data_out, exp_data);
        check_eq("rand_busy", busy_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
